// File: rtl/imem_fetch_responder_pkg.sv
// Shared Y86 fetch definitions: icodes, status encodings, FSM states and length decode.
package imem_fetch_responder_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [0:3] STAT_AOK = 4'b1000;
  localparam logic [0:3] STAT_HLT = 4'b0100;
  localparam logic [0:3] STAT_ADR = 4'b0010;
  localparam logic [0:3] STAT_INS = 4'b0001;

  localparam int MAX_LEN = 10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  // Undefined icodes report length 1 so only the offending byte is returned.
  function automatic logic [3:0] icode_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:              icode_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  icode_len = 4'd2;
      I_JXX, I_CALL:                     icode_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      icode_len = 4'd10;
      default:                           icode_len = 4'd1;
    endcase
  endfunction

  function automatic logic icode_invalid(input logic [3:0] icode);
    return icode > I_POPQ;
  endfunction

endpackage

// File: rtl/imem_fetch_responder_ilen_decode.sv
// Combinational Y86 instruction length decoder, shared with the fetch stage.
module y86_ilen_decode
  import imem_fetch_responder_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       ins_err
);

  assign len     = icode_len(icode);
  assign ins_err = icode_invalid(icode);

endmodule

// File: rtl/imem_fetch_responder.sv
// Y86 instruction fetch responder: gathers up to ten bytes from a synchronous byte memory.
// Optional flush input is present when IMEM_FETCH_FLUSH_EN is defined.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef IMEM_FETCH_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_pc,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [0:79]   rsp_instr,
  output logic [3:0]    rsp_len,
  output logic [0:3]    rsp_stat
);

  localparam int CW = AW + 2;
  localparam logic [CW-1:0] MEM_END = CW'(MEM_BYTES);

  state_t        state_reg;
  logic [AW-1:0] pc_reg;
  logic [3:0]    issue_cnt_reg;
  logic [3:0]    recv_cnt_reg;
  logic [3:0]    icode_reg;
  logic          rd_valid_reg;
  logic [0:79]   instr_reg;
  logic [0:79]   instr_next;
  logic          rsp_valid_reg;
  logic [0:79]   rsp_instr_reg;
  logic [3:0]    rsp_len_reg;
  logic [0:3]    rsp_stat_reg;
  logic [0:3]    stat_next;

  logic          flush_i;
  logic [CW-1:0] pc_ext;
  logic [CW-1:0] issue_addr;
  logic [CW-1:0] avail;
  logic [CW-1:0] need;
  logic [3:0]    issue_len;
  logic [3:0]    len_lim;
  logic          issue_go;
  logic          byte0_now;
  logic [3:0]    dec_icode;
  logic [3:0]    dec_len;
  logic          dec_ins;
  logic          capture;
  logic [3:0]    recv_next;
  logic          done;
  logic          adr_err;

`ifdef IMEM_FETCH_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign req_ready = (state_reg == IDLE) && !flush_i;

  // Until byte 0 is captured only two bytes may be in flight (byte 1 is speculative).
  assign pc_ext     = {2'b00, pc_reg};
  assign issue_addr = pc_ext + CW'(issue_cnt_reg);
  assign issue_len  = icode_len(icode_reg);
  assign len_lim    = (recv_cnt_reg != 4'd0) ? issue_len : 4'd2;
  assign issue_go   = (state_reg == FETCH) && !flush_i &&
                      (issue_cnt_reg < len_lim) && (issue_addr < MEM_END);

  assign mem_en   = issue_go;
  assign mem_addr = issue_go ? issue_addr[AW-1:0] : '0;

  assign byte0_now = rd_valid_reg && (recv_cnt_reg == 4'd0);
  assign dec_icode = byte0_now ? mem_rdata[7:4] : icode_reg;

  y86_ilen_decode u_ilen (
    .icode   (dec_icode),
    .len     (dec_len),
    .ins_err (dec_ins)
  );

  assign capture   = (state_reg == FETCH) && !flush_i && rd_valid_reg && (recv_cnt_reg < dec_len);
  assign recv_next = recv_cnt_reg + 4'd1;
  assign avail     = MEM_END - pc_ext;
  assign need      = (CW'(dec_len) < avail) ? CW'(dec_len) : avail;
  assign done      = capture && (CW'(recv_next) >= need);
  assign adr_err   = (pc_ext + CW'(dec_len)) > MEM_END;

  always_comb begin
    stat_next = STAT_AOK;
    if (adr_err)
      stat_next = STAT_ADR;
    else if (dec_ins)
      stat_next = STAT_INS;
    else if (dec_icode == I_HALT)
      stat_next = STAT_HLT;
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_slot
      assign instr_next[8*gi +: 8] = (capture && (recv_cnt_reg == 4'(gi))) ?
                                     mem_rdata : instr_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
      icode_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      instr_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_instr_reg <= '0;
      rsp_len_reg   <= '0;
      rsp_stat_reg  <= STAT_AOK;
    end else begin
      case (state_reg)
        IDLE: begin
          rd_valid_reg <= 1'b0;
          if (req_valid && req_ready) begin
            issue_cnt_reg <= '0;
            recv_cnt_reg  <= '0;
            icode_reg     <= '0;
            instr_reg     <= '0;
            if (req_pc < 64'(MEM_BYTES)) begin
              pc_reg    <= req_pc[AW-1:0];
              state_reg <= FETCH;
            end else begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_instr_reg <= '0;
              rsp_len_reg   <= 4'd1;
              rsp_stat_reg  <= STAT_ADR;
            end
          end
        end
        FETCH: begin
          if (flush_i) begin
            state_reg    <= IDLE;
            rd_valid_reg <= 1'b0;
          end else begin
            rd_valid_reg <= issue_go;
            if (issue_go)
              issue_cnt_reg <= issue_cnt_reg + 4'd1;
            if (capture) begin
              instr_reg    <= instr_next;
              recv_cnt_reg <= recv_next;
              if (byte0_now)
                icode_reg <= mem_rdata[7:4];
            end
            if (done) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_instr_reg <= instr_next;
              rsp_len_reg   <= dec_len;
              rsp_stat_reg  <= stat_next;
            end
          end
        end
        RESP: begin
          rd_valid_reg <= 1'b0;
          if (flush_i || rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_instr_reg <= '0;
            rsp_len_reg   <= '0;
            rsp_stat_reg  <= STAT_AOK;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_instr = rsp_instr_reg;
  assign rsp_len   = rsp_len_reg;
  assign rsp_stat  = rsp_stat_reg;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: directed table, hand sequences, random vs. model.
// The flush sequence is exercised only when IMEM_FETCH_FLUSH_EN is defined.
module tb_imem_fetch_responder;

  localparam int MEM = 1024;
  localparam int AW  = 10;
  localparam int NV  = 9;

  typedef struct {
    logic [63:0] pc;
    int          hold;
    logic [0:79] instr;
    int          len;
    logic [0:3]  stat;
    int          lat;
    int          pulses;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_pc;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [0:79]   rsp_instr;
  logic [3:0]    rsp_len;
  logic [0:3]    rsp_stat;
`ifdef IMEM_FETCH_FLUSH_EN
  logic          flush;
`endif

  logic [7:0] tb_mem [0:MEM-1];
  int total_pulses = 0;
  int bad_addr     = 0;
  int cur_base     = 0;
  int n_checks     = 0;
  int n_fail       = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  imem_fetch_responder #(.MEM_BYTES(MEM), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef IMEM_FETCH_FLUSH_EN
    .flush     (flush),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_len   (rsp_len),
    .rsp_stat  (rsp_stat)
  );

  // Synchronous byte memory plus read-pulse and address-window monitor.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata    <= tb_mem[mem_addr];
      total_pulses <= total_pulses + 1;
      if (int'(mem_addr) < cur_base || int'(mem_addr) > cur_base + 9)
        bad_addr <= bad_addr + 1;
    end
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int spec_len(input int icode);
    if (icode == 0 || icode == 1 || icode == 9) return 1;
    if (icode == 2 || icode == 6 || icode == 10 || icode == 11) return 2;
    if (icode == 7 || icode == 8) return 9;
    if (icode >= 3 && icode <= 5) return 10;
    return 1;
  endfunction

  // Expected response computed directly from memory contents and the fetch rules.
  function automatic vec_t model(input logic [63:0] pc, input int hold);
    vec_t v;
    int base, icode, len, avail, n;
    v.pc = pc; v.hold = hold; v.instr = '0;
    if (pc >= 64'(MEM)) begin
      v.len = 1; v.stat = 4'b0010; v.lat = 1; v.pulses = 0;
      return v;
    end
    base  = int'(pc[31:0]);
    icode = int'(tb_mem[base][7:4]);
    len   = spec_len(icode);
    avail = MEM - base;
    n     = (len < avail) ? len : avail;
    for (int k = 0; k < n; k++) v.instr[8*k +: 8] = tb_mem[base + k];
    v.len = len;
    if (len > avail)      v.stat = 4'b0010;
    else if (icode > 11)  v.stat = 4'b0001;
    else if (icode == 0)  v.stat = 4'b0100;
    else                  v.stat = 4'b1000;
    v.lat    = (n == len) ? len + 2 : -1;
    v.pulses = ((len == 1) ? 2 : len) < avail ? ((len == 1) ? 2 : len) : avail;
    return v;
  endfunction

  task automatic run_txn(input vec_t e, input int idx);
    logic [0:79] g_instr;
    logic [3:0]  g_len;
    logic [0:3]  g_stat;
    int g_lat, p0, waitc;
    cur_base = (e.pc < 64'(MEM)) ? int'(e.pc[31:0]) : -100;
    @(negedge clk);
    req_pc = e.pc; req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    p0 = total_pulses;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g_lat = 1;
    while (!rsp_valid && g_lat < 40) begin @(posedge clk); #1; g_lat++; end
    g_instr = rsp_instr; g_len = rsp_len; g_stat = rsp_stat;
    chk("rsp_seen", 80'(rsp_valid), 80'(1));
    if (e.lat >= 0) chk("latency", 80'(g_lat), 80'(e.lat));
    chk("instr", g_instr, e.instr);
    chk("len", 80'(g_len), 80'(e.len));
    chk("stat", 80'(g_stat), 80'(e.stat));
    for (int h = 0; h < e.hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 80'(rsp_valid), 80'(1));
      chk("hold_instr", rsp_instr, e.instr);
      chk("hold_len", 80'(rsp_len), 80'(e.len));
      chk("hold_stat", 80'(rsp_stat), 80'(e.stat));
      chk("hold_ready", 80'(req_ready), 80'(0));
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("pulses", 80'(total_pulses - p0), 80'(e.pulses));
    chk("idle_valid", 80'(rsp_valid), 80'(0));
    chk("idle_instr", rsp_instr, 80'(0));
    chk("idle_len", 80'(rsp_len), 80'(0));
    chk("idle_stat", 80'(rsp_stat), 80'(4'b1000));
    chk("idle_ready", 80'(req_ready), 80'(1));
    $display("txn %0d pc=0x%0h instr=%h len=%0d stat=%b lat=%0d pulses=%0d",
             idx, e.pc, g_instr, g_len, g_stat, g_lat, total_pulses - p0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rpc;
    vec_t rv;
    int sel;
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
`ifdef IMEM_FETCH_FLUSH_EN
    flush = 1'b0;
`endif
    for (int i = 0; i < MEM; i++) tb_mem[i] = 8'h00;
    tb_mem[0] = 8'h10; tb_mem[1] = 8'h55;
    tb_mem[5] = 8'hC0; tb_mem[6] = 8'h00;
    tb_mem[32'h20] = 8'h30; tb_mem[32'h21] = 8'hF3;
    for (int k = 0; k < 8; k++) tb_mem[32'h22 + k] = 8'(k + 1);
    tb_mem[32'h40] = 8'h60; tb_mem[32'h41] = 8'h12; tb_mem[32'h42] = 8'h77;
    tb_mem[32'h50] = 8'h70;
    for (int k = 1; k < 9; k++) tb_mem[32'h50 + k] = 8'(8'h10 + k);
    tb_mem[32'h59] = 8'hEE;
    tb_mem[1020] = 8'h30; tb_mem[1021] = 8'hF3; tb_mem[1022] = 8'hAA; tb_mem[1023] = 8'hBB;
    tb_mem[0] = 8'h10;

    vecs[0] = '{64'h0, 0, {8'h10, 72'h0}, 1, 4'b1000, 3, 2};
    vecs[1] = '{64'h20, 5, {8'h30, 8'hF3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
                10, 4'b1000, 12, 10};
    vecs[2] = '{64'd1020, 0, {8'h30, 8'hF3, 8'hAA, 8'hBB, 48'h0}, 10, 4'b0010, -1, 4};
    vecs[3] = '{64'd1024, 0, 80'h0, 1, 4'b0010, 1, 0};
    vecs[4] = '{64'd5, 0, {8'hC0, 72'h0}, 1, 4'b0001, 3, 2};
    vecs[5] = '{64'd6, 0, 80'h0, 1, 4'b0100, 3, 2};
    vecs[6] = '{64'h40, 1, {8'h60, 8'h12, 64'h0}, 2, 4'b1000, 4, 2};
    vecs[7] = '{64'h50, 0, {8'h70, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h00},
                9, 4'b1000, 11, 9};
    vecs[8] = '{64'h7FFF_FFFF_FFFF_0000, 2, 80'h0, 1, 4'b0010, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 80'(req_ready), 80'(1));
    chk("rst_mem_en", 80'(mem_en), 80'(0));
    chk("rst_mem_addr", 80'(mem_addr), 80'(0));
    chk("rst_rsp_valid", 80'(rsp_valid), 80'(0));
    chk("rst_rsp_instr", rsp_instr, 80'(0));
    chk("rst_rsp_len", 80'(rsp_len), 80'(0));
    chk("rst_rsp_stat", 80'(rsp_stat), 80'(4'b1000));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_txn(vecs[i], i);

    // Reset asserted in the middle of a ten-byte fetch.
    cur_base = 32'h20;
    @(negedge clk); req_pc = 64'h20; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_mem_en", 80'(mem_en), 80'(1));
    chk("mid_mem_addr", 80'(mem_addr), 80'(32'h23));
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 80'(req_ready), 80'(1));
    chk("arst_mem_en", 80'(mem_en), 80'(0));
    chk("arst_mem_addr", 80'(mem_addr), 80'(0));
    chk("arst_rsp_valid", 80'(rsp_valid), 80'(0));
    chk("arst_rsp_stat", 80'(rsp_stat), 80'(4'b1000));
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_txn(vecs[0], 100);

`ifdef IMEM_FETCH_FLUSH_EN
    cur_base = 32'h20;
    @(negedge clk); req_pc = 64'h20; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_idle_ready", 80'(req_ready), 80'(1));
    chk("flush_no_valid", 80'(rsp_valid), 80'(0));
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("flush_no_rsp", 80'(seen), 80'(0));
    @(negedge clk); flush = 1'b1;
    #1;
    chk("flush_blocks_ready", 80'(req_ready), 80'(0));
    @(negedge clk); flush = 1'b0;
    run_txn(vecs[1], 200);
`endif

    for (int i = 0; i < MEM; i++) tb_mem[i] = 8'($urandom);
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)
        rpc = {32'($urandom), 32'($urandom)} | 64'h400;
      else if (sel < 4)
        rpc = 64'($urandom_range(1012, 1023));
      else
        rpc = 64'($urandom_range(0, 1011));
      rv = model(rpc, $urandom_range(0, 2));
      run_txn(rv, 300 + t);
    end

    chk("addr_window", 80'(bad_addr), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
